// File: rtl/vec3_normalize_seq.sv
// vec3_normalize_seq
// Multi-cycle normalizer for a signed Q(WIDTH-FRAC).FRAC 3D vector: returns v/|v|.
// Sum of squares (1 cycle), restoring bit-serial square root (WIDTH cycles), a zero check
// (1 cycle), then three restoring bit-serial divides (WIDTH+FRAC cycles each).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is high only when idle
//   x, y, z             signed input components, latched on accept
//   out_valid/out_ready output handshake; result held until accepted
//   nx, ny, nz          signed normalized components
//   zero_flag           input was the zero vector (outputs forced to 0)
module vec3_normalize_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] nx,
  output logic [WIDTH-1:0] ny,
  output logic [WIDTH-1:0] nz,
  output logic             zero_flag
);

  localparam int unsigned SW = 2 * WIDTH;        // sum of squares width
  localparam int unsigned DW = WIDTH + FRAC;     // divide dividend / quotient width
  localparam int unsigned RW = WIDTH + 4;        // square-root partial remainder width
  localparam int unsigned CW = $clog2(DW + 1);   // step counter width

  typedef enum logic [2:0] {
    StIdle, StSumsq, StSqrt, StCheck, StDivx, StDivy, StDivz, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [SW-1:0]    s_q, s_d;
  logic [RW-1:0]    srem_q, srem_d;
  logic [WIDTH-1:0] root_q, root_d;  // holds mag once the square root finishes
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0] drem_q, drem_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  function automatic logic [WIDTH-1:0] abs_c(input logic [WIDTH-1:0] c);
    // -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
    return c[WIDTH-1] ? -c : c;
  endfunction

  function automatic logic [SW-1:0] square(input logic [WIDTH-1:0] a);
    logic [SW-1:0] e;
    e = {{WIDTH{1'b0}}, a};
    return e * e;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [DW-1:0] q);
    logic [DW-1:0] r;
    r = neg ? -q : q;
    return WIDTH'(r);
  endfunction

  logic [WIDTH-1:0] ax, ay, az;
  logic [SW-1:0]    sum_sq;
  logic [RW-1:0]    srem_sh, trial;
  logic             sqrt_ge, sqrt_last;
  logic [WIDTH:0]   drem_sh, mag_ext;
  logic             div_ge, div_last;
  logic [DW-1:0]    quo_nxt;
  logic             comp_neg;
  logic [WIDTH-1:0] div_res;

  always_comb begin
    ax = abs_c(x_q);
    ay = abs_c(y_q);
    az = abs_c(z_q);
    // Worst case 3*2^(2*WIDTH-2) still fits in SW bits.
    sum_sq = square(ax) + square(ay) + square(az);

    // Restoring square root: bring down two radicand bits, try 4*root+1.
    srem_sh   = RW'({srem_q, s_q[SW-1 -: 2]});
    trial     = {2'b00, root_q, 2'b01};
    sqrt_ge   = (srem_sh >= trial);
    sqrt_last = (cnt_q == CW'(WIDTH - 1));

    // Restoring divide: bring down one dividend bit, try subtracting mag.
    drem_sh  = {drem_q, dvd_q[DW-1]};
    mag_ext  = {1'b0, root_q};
    div_ge   = (drem_sh >= mag_ext);
    div_last = (cnt_q == CW'(DW - 1));
    quo_nxt  = DW'({quo_q, div_ge});

    unique case (state_q)
      StDivy:  comp_neg = y_q[WIDTH-1];
      StDivz:  comp_neg = z_q[WIDTH-1];
      default: comp_neg = x_q[WIDTH-1];
    endcase
    // Magnitude quotient never exceeds 1.0, so the low WIDTH bits hold it exactly.
    div_res = apply_sign(comp_neg, quo_nxt);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    s_d         = s_q;
    srem_d      = srem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    drem_d      = drem_q;
    quo_d       = quo_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    nz_d        = nz_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          z_d     = z;
          zero_d  = 1'b0;
          state_d = StSumsq;
        end
      end
      StSumsq: begin
        s_d     = sum_sq;
        srem_d  = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = StSqrt;
      end
      StSqrt: begin
        s_d    = s_q << 2;
        srem_d = sqrt_ge ? (srem_sh - trial) : srem_sh;
        root_d = WIDTH'({root_q, sqrt_ge});
        cnt_d  = cnt_q + CW'(1);
        if (sqrt_last) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (root_q == '0) begin
          zero_d      = 1'b1;
          nx_d        = '0;
          ny_d        = '0;
          nz_d        = '0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          dvd_d   = {ax, {FRAC{1'b0}}};
          drem_d  = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = StDivx;
        end
      end
      StDivx, StDivy, StDivz: begin
        drem_d = WIDTH'(div_ge ? (drem_sh - mag_ext) : drem_sh);
        dvd_d  = dvd_q << 1;
        quo_d  = quo_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (div_last) begin
          drem_d = '0;
          quo_d  = '0;
          cnt_d  = '0;
          unique case (state_q)
            StDivx: begin
              nx_d    = div_res;
              dvd_d   = {ay, {FRAC{1'b0}}};
              state_d = StDivy;
            end
            StDivy: begin
              ny_d    = div_res;
              dvd_d   = {az, {FRAC{1'b0}}};
              state_d = StDivz;
            end
            default: begin
              nz_d        = div_res;
              out_valid_d = 1'b1;
              state_d     = StDone;
            end
          endcase
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      s_q         <= '0;
      srem_q      <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      dvd_q       <= '0;
      drem_q      <= '0;
      quo_q       <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      nz_q        <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      s_q         <= s_d;
      srem_q      <= srem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      drem_q      <= drem_d;
      quo_q       <= quo_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      nz_q        <= nz_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign nx        = nx_q;
  assign ny        = ny_q;
  assign nz        = nz_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_vec3_normalize_seq.sv
// Testbench for vec3_normalize_seq: scoreboard of expected results from a reference model.
module tb_vec3_normalize_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] x = '0, y = '0, z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] nx, ny, nz;
  logic        zero_flag;

  typedef struct {
    logic [11:0] nx;
    logic [11:0] ny;
    logic [11:0] nz;
    logic        zf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vec3_normalize_seq #(.WIDTH(12), .FRAC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nx        (nx),
    .ny        (ny),
    .nz        (nz),
    .zero_flag (zero_flag)
  );

  // Reference: integer floor-sqrt by search, truncating divide of |c|*16 by mag, sign reapplied.
  function automatic exp_t model(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    exp_t        e;
    int          v[3];
    int          s, m, q, r;
    logic [31:0] t[3];
    v[0] = int'($signed(a));
    v[1] = int'($signed(b));
    v[2] = int'($signed(c));
    s = v[0] * v[0] + v[1] * v[1] + v[2] * v[2];
    m = 0;
    while ((m + 1) * (m + 1) <= s) m++;
    for (int i = 0; i < 3; i++) begin
      if (m == 0) r = 0;
      else begin
        q = ((v[i] < 0 ? -v[i] : v[i]) * 16) / m;
        r = (v[i] < 0) ? -q : q;
      end
      t[i] = r;
    end
    e.nx  = t[0][11:0];
    e.ny  = t[1][11:0];
    e.nz  = t[2][11:0];
    e.zf  = (m == 0);
    e.lat = (m == 0) ? 14 : 62;
    return e;
  endfunction

  task automatic send(input logic [11:0] vx, input logic [11:0] vy, input logic [11:0] vz);
    int i;
    sb.push_back(model(vx, vy, vz));
    @(negedge clk);
    in_valid = 1'b1;
    x = vx;
    y = vy;
    z = vz;
    i = 0;
    while (!in_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, i);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs after the accept edge; the latched vector must be used.
    x = 12'($urandom);
    y = 12'($urandom);
    z = 12'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 300);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, nx, ny, nz, zero_flag} !== {1'b1, 1'b0, 36'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_hold: rdy=%b vld=%b n=%h %h %h zf=%b, expected rdy=1 vld=0 zeros",
               in_ready, out_valid, nx, ny, nz, zero_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [35:0] tbl[5];
    exp_t        e;
    int          lat;
    tbl[0] = {12'h010, 12'h000, 12'h000};
    tbl[1] = {12'h030, 12'h040, 12'h000};
    tbl[2] = {12'hFD0, 12'h000, 12'h040};
    tbl[3] = {12'h800, 12'h800, 12'h800};
    tbl[4] = {12'h030, 12'hF40, 12'h050};
    for (int i = 0; i < 5; i++) begin
      send(tbl[i][35:24], tbl[i][23:12], tbl[i][11:0]);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_bad++;
        $display("FAIL vec%0d_latency: got %0d, expected %0d", i, lat, e.lat);
      end
      n_cmp++;
      if ({nx, ny, nz, zero_flag} !== {e.nx, e.ny, e.nz, e.zf}) begin
        n_bad++;
        $display("FAIL vec%0d_result: got %h %h %h zf=%b, expected %h %h %h zf=%b",
                 i, nx, ny, nz, zero_flag, e.nx, e.ny, e.nz, e.zf);
      end
      take();
    end
  endtask

  task automatic test_zero();
    exp_t e;
    int   lat;
    send(12'h000, 12'h000, 12'h000);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL zero_latency: got %0d, expected %0d", lat, e.lat);
    end
    n_cmp++;
    if ({nx, ny, nz, zero_flag} !== {e.nx, e.ny, e.nz, e.zf}) begin
      n_bad++;
      $display("FAIL zero_result: got %h %h %h zf=%b, expected %h %h %h zf=%b",
               nx, ny, nz, zero_flag, e.nx, e.ny, e.nz, e.zf);
    end
    take();
    send(12'h010, 12'h000, 12'h000);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++;
    if ({lat, nx, ny, nz, zero_flag} !== {e.lat, e.nx, e.ny, e.nz, e.zf}) begin
      n_bad++;
      $display("FAIL zero_then_unit: got lat=%0d %h %h %h zf=%b, expected lat=%0d %h %h %h zf=%b",
               lat, nx, ny, nz, zero_flag, e.lat, e.nx, e.ny, e.nz, e.zf);
    end
    take();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    send(12'h030, 12'h040, 12'h000);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d, expected %0d", lat, e.lat);
    end
    @(negedge clk);
    in_valid = 1'b1;
    x = 12'h100;
    y = 12'h020;
    z = 12'hF00;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, nx, ny, nz, zero_flag} !== {2'b10, e.nx, e.ny, e.nz, e.zf}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b %h %h %h zf=%b, expected vld=1 rdy=0 %h %h %h zf=%b",
                 i, out_valid, in_ready, nx, ny, nz, zero_flag, e.nx, e.ny, e.nz, e.zf);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: rdy=%b vld=%b, expected rdy=1 vld=0 (pending vector not taken)",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    logic seen;
    send(12'h030, 12'h0C0, 12'h050);
    repeat (35) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL rstmid_assert: vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_release: rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_partial: out_valid seen=%b, expected 0", seen);
    end
    send(12'hFD0, 12'h000, 12'h040);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++;
    if ({lat, nx, ny, nz, zero_flag} !== {e.lat, e.nx, e.ny, e.nz, e.zf}) begin
      n_bad++;
      $display("FAIL rstmid_fresh: got lat=%0d %h %h %h zf=%b, expected lat=%0d %h %h %h zf=%b",
               lat, nx, ny, nz, zero_flag, e.lat, e.nx, e.ny, e.nz, e.zf);
    end
    take();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) send(12'h000, 12'h000, 12'h000);
      else send(12'h7FF, 12'h123 + 12'(i), 12'hE80);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++;
      if ({lat, nx, ny, nz, zero_flag} !== {e.lat, e.nx, e.ny, e.nz, e.zf}) begin
        n_bad++;
        $display("FAIL b2b%0d: got lat=%0d %h %h %h zf=%b, expected lat=%0d %h %h %h zf=%b",
                 i, lat, nx, ny, nz, zero_flag, e.lat, e.nx, e.ny, e.nz, e.zf);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
